// File: rtl/pipeline_stall_controller_pkg.sv
// Shared pipeline definitions: stall-controller FSM encodings and multiply-latency bounds.
package pipeline_stall_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MUL_WAIT = 2'd2
  } state_e;

  localparam int MUL_LAT_MIN = 2;
  localparam int MUL_LAT_MAX = 8;
  // Wide enough for the largest preload value, MUL_LAT_MAX-2.
  localparam int MUL_CNT_W   = 3;

endpackage

// File: rtl/pipeline_stall_controller_mul_cycle_counter.sv
// Loadable down-counter with zero-detect that times the multiply hold window.
module mul_cycle_counter #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (load_i) begin
      cnt <= load_val_i;
    end else if (dec_i && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero_o = (cnt == '0);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Hazard/stall controller: freezes or flushes pipeline registers for memory waits,
// multi-cycle multiplies, taken branches and load-use hazards.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IF_ID_rs_i,
  input  logic [4:0]       IF_ID_rt_i,
  input  logic [4:0]       ID_EX_rt_i,
  input  logic             ID_EX_MemRead_i,
  input  logic             PCSrc_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  input  logic             mul_start_i,
  output logic             PCStall_o,
  output logic             IFIDStall_o,
  output logic             IDEXStall_o,
  output logic             EXMEMStall_o,
  output logic             IFIDFlush_o,
  output logic             IDFlush_o,
  output logic             EXFlush_o,
  output logic             busy_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  if (MUL_LAT < MUL_LAT_MIN || MUL_LAT > MUL_LAT_MAX) begin : g_bad_mul_lat
    $error("pipeline_stall_controller: MUL_LAT out of range 2..8");
  end

  localparam logic [MUL_CNT_W-1:0] MUL_LOAD = MUL_CNT_W'(MUL_LAT - 2);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e           state, state_nxt;
  logic             mul_load, mul_dec, mul_zero;
  logic             pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic             ifid_flush, id_flush, ex_flush;
  logic             load_use, mem_wait;
  logic [CNT_W-1:0] stall_cnt;

  assign mem_wait = dmem_req_i && !dmem_ready_i;
  assign load_use = ID_EX_MemRead_i && (ID_EX_rt_i != 5'd0) &&
                    ((ID_EX_rt_i == IF_ID_rs_i) || (ID_EX_rt_i == IF_ID_rt_i));

  mul_cycle_counter #(.W(MUL_CNT_W)) u_mul_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (mul_load),
    .load_val_i (MUL_LOAD),
    .dec_i      (mul_dec),
    .zero_o     (mul_zero)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= ST_RUN;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (PCStall_o) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  always_comb begin
    state_nxt   = state;
    mul_load    = 1'b0;
    mul_dec     = 1'b0;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    ifid_flush  = 1'b0;
    id_flush    = 1'b0;
    ex_flush    = 1'b0;
    case (state)
      ST_RUN: begin
        if (mem_wait) begin
          {pc_stall, ifid_stall, idex_stall, exmem_stall} = 4'b1111;
          state_nxt = ST_MEM_WAIT;
        end else if (mul_start_i) begin
          // EX is occupied, so a bubble goes into MEM while upstream holds.
          {pc_stall, ifid_stall, idex_stall, ex_flush} = 4'b1111;
          mul_load  = 1'b1;
          state_nxt = ST_MUL_WAIT;
        end else if (PCSrc_i) begin
          {ifid_flush, id_flush, ex_flush} = 3'b111;
        end else if (load_use) begin
          {pc_stall, ifid_stall, id_flush} = 3'b111;
        end
      end
      ST_MEM_WAIT: begin
        if (!dmem_ready_i) begin
          {pc_stall, ifid_stall, idex_stall, exmem_stall} = 4'b1111;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_MUL_WAIT: begin
        if (!mul_zero) begin
          {pc_stall, ifid_stall, idex_stall, ex_flush} = 4'b1111;
          mul_dec = 1'b1;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Outputs are combinational from inputs, so they must be forced quiet while in reset.
  assign PCStall_o    = rst_i & pc_stall;
  assign IFIDStall_o  = rst_i & ifid_stall;
  assign IDEXStall_o  = rst_i & idex_stall;
  assign EXMEMStall_o = rst_i & exmem_stall;
  assign IFIDFlush_o  = rst_i & ifid_flush;
  assign IDFlush_o    = rst_i & id_flush;
  assign EXFlush_o    = rst_i & ex_flush;
  assign busy_o       = rst_i & (state != ST_RUN);
  assign state_o      = state;
  assign stall_cnt_o  = stall_cnt;

endmodule
